// File: rtl/queen_pkg.sv
// queen_pkg: shared constants, FSM state codes and diagonal index
// helpers for the twelve-queens completion engine.
package queen_pkg;

    localparam int N      = 12;
    localparam int ROW_W  = 4;
    localparam int DIAG_W = 2 * N - 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SEARCH = 2'd2;
    localparam logic [1:0] ST_OUT    = 2'd3;

    typedef logic [ROW_W-1:0] row_t;

    // Anti-diagonal index: col + row, range 0..2N-2.
    function automatic logic [4:0] dsum_idx(input row_t c, input row_t r);
        return {1'b0, c} + {1'b0, r};
    endfunction

    // Main-diagonal index: col - row + (N-1), range 0..2N-2.
    function automatic logic [4:0] ddif_idx(input row_t c, input row_t r);
        return {1'b0, c} + 5'(N - 1) - {1'b0, r};
    endfunction

endpackage

// File: rtl/queen_solver_if.sv
// queen_solver_if: board handshake bundle between pattern and solver.
// master drives queens (in_valid/in_valid_num/in_num/col/row),
// slave returns the 12-beat answer (out_valid/out).
interface queen_solver_if
    import queen_pkg::*;
;
    logic       in_valid;
    logic       in_valid_num;
    logic [2:0] in_num;
    row_t       col;
    row_t       row;
    logic       out_valid;
    row_t       out;

    modport master (
        output in_valid, in_valid_num, in_num, col, row,
        input  out_valid, out
    );

    modport slave (
        input  in_valid, in_valid_num, in_num, col, row,
        output out_valid, out
    );

endinterface

// File: rtl/queen_row_finder.sv
// queen_row_finder: lowest free row >= start in column c.
// Ports: c_i, start_i, three attack masks in; found_o, r_o out.
module queen_row_finder
    import queen_pkg::*;
(
    input  row_t              c_i,
    input  logic [4:0]        start_i,
    input  logic [N-1:0]      row_used_i,
    input  logic [DIAG_W-1:0] diag_sum_i,
    input  logic [DIAG_W-1:0] diag_dif_i,
    output logic              found_o,
    output row_t              r_o
);

    logic [N-1:0] free;
    logic [N-1:0] cand;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            free[i] = !row_used_i[i]
                   && !diag_sum_i[dsum_idx(c_i, row_t'(i))]
                   && !diag_dif_i[ddif_idx(c_i, row_t'(i))];
        end
    end

    // A start of N or more shifts every candidate out: "not found".
    assign cand = free & ({N{1'b1}} << start_i);

    always_comb begin
        found_o = |cand;
        r_o     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) r_o = row_t'(i);
        end
    end

endmodule

// File: rtl/queen_solver.sv
// queen_solver: loads 1..7 fixed queens, completes the board by
// depth-first search, then streams pos[0..11] on out for 12 beats.
// Ports: clk, rst_n (async, active-low), q_if (slave side of the bus).
module queen_solver
    import queen_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    queen_solver_if.slave q_if
);

    logic [1:0]        state_q, state_d;
    row_t              pos_q [N];
    row_t              pos_d [N];
    logic [N-1:0]      fixed_q, fixed_d;
    logic [N-1:0]      rused_q, rused_d;
    logic [DIAG_W-1:0] dsum_q, dsum_d;
    logic [DIAG_W-1:0] ddif_q, ddif_d;
    logic [4:0]        c_q, c_d;
    logic [4:0]        st_q, st_d;
    logic [3:0]        k_q, k_d;
    logic [2:0]        num_q, num_d;
    logic [2:0]        cnt_q, cnt_d;

    row_t cur;
    row_t p;
    row_t r_fnd;
    logic found;
    logic rec;
    logic out_valid;

    assign cur = c_q[ROW_W-1:0];

    queen_row_finder u_finder (
        .c_i        (cur),
        .start_i    (st_q),
        .row_used_i (rused_q),
        .diag_sum_i (dsum_q),
        .diag_dif_i (ddif_q),
        .found_o    (found),
        .r_o        (r_fnd)
    );

    // Backtrack target: highest non-fixed column below c.
    always_comb begin
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (5'(i) < c_q && !fixed_q[i]) p = row_t'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        fixed_d = fixed_q;
        rused_d = rused_q;
        dsum_d  = dsum_q;
        ddif_d  = ddif_q;
        c_d     = c_q;
        st_d    = st_q;
        k_d     = k_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        rec     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (q_if.in_valid) begin
                    if (q_if.in_valid_num) num_d = q_if.in_num;
                    cnt_d   = 3'd1;
                    rec     = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (q_if.in_valid) begin
                    cnt_d = cnt_q + 3'd1;
                    rec   = 1'b1;
                end else begin
                    state_d = ST_SEARCH;
                    c_d     = '0;
                    st_d    = '0;
                end
            end
            ST_SEARCH: begin
                if (c_q == 5'(N)) begin
                    state_d = ST_OUT;
                    k_d     = '0;
                end else if (fixed_q[cur]) begin
                    c_d = c_q + 5'd1;
                end else if (found) begin
                    pos_d[cur]                  = r_fnd;
                    rused_d[r_fnd]              = 1'b1;
                    dsum_d[dsum_idx(cur, r_fnd)] = 1'b1;
                    ddif_d[ddif_idx(cur, r_fnd)] = 1'b1;
                    c_d  = c_q + 5'd1;
                    st_d = '0;
                end else begin
                    rused_d[pos_q[p]]               = 1'b0;
                    dsum_d[dsum_idx(p, pos_q[p])]   = 1'b0;
                    ddif_d[ddif_idx(p, pos_q[p])]   = 1'b0;
                    c_d  = {1'b0, p};
                    st_d = {1'b0, pos_q[p]} + 5'd1;
                end
            end
            ST_OUT: begin
                k_d = k_q + 4'd1;
                if (k_q == 4'(N - 1)) begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                    fixed_d = '0;
                    rused_d = '0;
                    dsum_d  = '0;
                    ddif_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rec) begin
            fixed_d[q_if.col]                       = 1'b1;
            pos_d[q_if.col]                         = q_if.row;
            rused_d[q_if.row]                       = 1'b1;
            dsum_d[dsum_idx(q_if.col, q_if.row)]    = 1'b1;
            ddif_d[ddif_idx(q_if.col, q_if.row)]    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < N; i++) pos_q[i] <= '0;
            fixed_q <= '0;
            rused_q <= '0;
            dsum_q  <= '0;
            ddif_q  <= '0;
            c_q     <= '0;
            st_q    <= '0;
            k_q     <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            fixed_q <= fixed_d;
            rused_q <= rused_d;
            dsum_q  <= dsum_d;
            ddif_q  <= ddif_d;
            c_q     <= c_d;
            st_q    <= st_d;
            k_q     <= k_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
        end
    end

    // The burst end comes from in_valid; in_num is only cross-checked.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == ST_LOAD && !q_if.in_valid)
            assert (cnt_q == num_q);
    end

    assign out_valid      = (state_q == ST_OUT);
    assign q_if.out_valid = out_valid;
    assign q_if.out       = out_valid ? pos_q[k_q] : '0;

endmodule

// File: tb/tb_queen_solver.sv
// tb_queen_solver: table-driven directed vectors plus reset and
// back-to-back sequences for queen_solver.
module tb_queen_solver;
    import queen_pkg::*;

    typedef struct packed {
        logic [2:0]       n;
        logic [6:0][3:0]  c;
        logic [6:0][3:0]  r;
        logic [11:0][3:0] exp;
    } vec_t;

    localparam int NV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    queen_solver_if bus ();

    queen_solver u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q_if  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    vec_t             vecs [NV];
    logic [11:0][3:0] gold;
    int               gold_i [12] = '{0, 2, 4, 7, 9, 11, 5, 10, 1, 6, 8, 3};

    int m_pos [12];
    bit m_fix [12];

    task automatic chk(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic logic [6:0][3:0] pk7(input int a0, a1, a2, a3,
                                             a4, a5, a6);
        logic [6:0][3:0] v;
        v[0] = 4'(a0); v[1] = 4'(a1); v[2] = 4'(a2); v[3] = 4'(a3);
        v[4] = 4'(a4); v[5] = 4'(a5); v[6] = 4'(a6);
        return v;
    endfunction

    // Reference: attack check against fixed queens and placed lower columns.
    function automatic bit safe(input int c, input int t);
        for (int j = 0; j < 12; j++) begin
            if (j != c && (m_fix[j] || j < c)) begin
                if (m_pos[j] == t) return 1'b0;
                if (m_pos[j] - t == j - c) return 1'b0;
                if (m_pos[j] - t == c - j) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic bit fix_safe(input int c, input int t);
        for (int j = 0; j < 12; j++) begin
            if (m_fix[j]) begin
                if (m_pos[j] == t) return 1'b0;
                if (m_pos[j] - t == j - c) return 1'b0;
                if (m_pos[j] - t == c - j) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic model(output bit ok);
        int c;
        int dir;
        int guard;
        bit f;
        c = 0; dir = 1; guard = 0;
        for (int j = 0; j < 12; j++) if (!m_fix[j]) m_pos[j] = -1;
        while (c >= 0 && c < 12 && guard < 200000) begin
            guard++;
            if (m_fix[c]) begin
                c += dir;
            end else begin
                f = 1'b0;
                for (int t = m_pos[c] + 1; t < 12 && !f; t++) begin
                    if (safe(c, t)) begin
                        m_pos[c] = t;
                        f = 1'b1;
                    end
                end
                if (f) begin
                    dir = 1; c++;
                end else begin
                    m_pos[c] = -1; dir = -1; c--;
                end
            end
        end
        ok = (c == 12);
    endtask

    task automatic gen_rand(output logic [2:0] n,
                            output logic [6:0][3:0] cs,
                            output logic [6:0][3:0] rs,
                            output logic [11:0][3:0] ex);
        bit ok;
        int nn, placed, cc, rr;
        ok = 1'b0; n = '0; cs = '0; rs = '0; ex = '0;
        for (int a = 0; a < 1000 && !ok; a++) begin
            nn = $urandom_range(1, 4);
            placed = 0;
            cs = '0; rs = '0;
            for (int j = 0; j < 12; j++) begin
                m_fix[j] = 1'b0; m_pos[j] = -1;
            end
            for (int t = 0; t < 60 && placed < nn; t++) begin
                cc = $urandom_range(0, 11);
                rr = $urandom_range(0, 11);
                if (!m_fix[cc] && fix_safe(cc, rr)) begin
                    m_fix[cc] = 1'b1; m_pos[cc] = rr;
                    cs[placed] = 4'(cc); rs[placed] = 4'(rr);
                    placed++;
                end
            end
            n = 3'(placed);
            model(ok);
        end
        for (int j = 0; j < 12; j++) ex[j] = 4'(m_pos[j]);
    endtask

    // Called at a negedge; leaves in_valid low at a negedge.
    task automatic send(input logic [2:0] n,
                        input logic [6:0][3:0] cs,
                        input logic [6:0][3:0] rs);
        for (int i = 0; i < int'(n); i++) begin
            chk($sformatf("burst v%0d", i), int'(bus.out_valid), 0);
            chk($sformatf("burst o%0d", i), int'(bus.out), 0);
            bus.in_valid     = 1'b1;
            bus.in_valid_num = (i == 0);
            bus.in_num       = (i == 0) ? n : 3'bx;
            bus.col          = cs[i];
            bus.row          = rs[i];
            @(negedge clk);
        end
        bus.in_valid     = 1'b0;
        bus.in_valid_num = 1'b0;
        bus.in_num       = 3'bx;
        bus.col          = '0;
        bus.row          = '0;
    endtask

    task automatic collect(input string nm, input logic [11:0][3:0] ex);
        bit got;
        bit dirty;
        got = 1'b0; dirty = 1'b0;
        for (int w = 0; w < 20000; w++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            if (bus.out != '0) dirty = 1'b1;
        end
        chk({nm, " out0 wait"}, int'(dirty), 0);
        chk({nm, " timeout"}, int'(got), 1);
        if (!got) return;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("%s v%0d", nm, k), int'(bus.out_valid), 1);
            chk($sformatf("%s b%0d", nm, k), int'(bus.out), int'(ex[k]));
        end
        @(negedge clk);
        chk({nm, " v end"}, int'(bus.out_valid), 0);
        chk({nm, " o end"}, int'(bus.out), 0);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]       rn;
        logic [6:0][3:0]  rc;
        logic [6:0][3:0]  rr;
        logic [11:0][3:0] re;
        bit               got;

        bus.in_valid     = 1'b0;
        bus.in_valid_num = 1'b0;
        bus.in_num       = '0;
        bus.col          = '0;
        bus.row          = '0;

        for (int k = 0; k < 12; k++) gold[k] = 4'(gold_i[k]);

        vecs[0] = '{n: 3'd1, c: pk7(0, 0, 0, 0, 0, 0, 0),
                    r: pk7(0, 0, 0, 0, 0, 0, 0), exp: gold};
        vecs[1] = '{n: 3'd1, c: pk7(11, 0, 0, 0, 0, 0, 0),
                    r: pk7(3, 0, 0, 0, 0, 0, 0), exp: gold};
        vecs[2] = '{n: 3'd3, c: pk7(0, 1, 2, 0, 0, 0, 0),
                    r: pk7(0, 2, 4, 0, 0, 0, 0), exp: gold};
        vecs[3] = '{n: 3'd7, c: pk7(0, 1, 2, 3, 4, 5, 6),
                    r: pk7(0, 2, 4, 7, 9, 11, 5), exp: gold};
        vecs[4] = '{n: 3'd2, c: pk7(5, 8, 0, 0, 0, 0, 0),
                    r: pk7(11, 1, 0, 0, 0, 0, 0), exp: gold};
        vecs[5] = '{n: 3'd4, c: pk7(11, 9, 7, 6, 0, 0, 0),
                    r: pk7(3, 6, 10, 5, 0, 0, 0), exp: gold};
        vecs[6] = '{n: 3'd1, c: pk7(6, 0, 0, 0, 0, 0, 0),
                    r: pk7(5, 0, 0, 0, 0, 0, 0), exp: gold};
        vecs[7] = '{n: 3'd7, c: pk7(3, 10, 1, 8, 5, 0, 9),
                    r: pk7(7, 8, 2, 1, 11, 0, 6), exp: gold};

        repeat (2) @(negedge clk);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset out", int'(bus.out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            send(vecs[i].n, vecs[i].c, vecs[i].r);
            collect($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset mid-burst: partial queens must be forgotten.
        send(3'd2, pk7(0, 1, 0, 0, 0, 0, 0), pk7(1, 3, 0, 0, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1 chk("rst burst v", int'(bus.out_valid), 0);
        chk("rst burst o", int'(bus.out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(3'd1, pk7(0, 0, 0, 0, 0, 0, 0), pk7(0, 0, 0, 0, 0, 0, 0));
        collect("after rst burst", gold);

        // Reset mid-search.
        send(3'd1, pk7(0, 0, 0, 0, 0, 0, 0), pk7(0, 0, 0, 0, 0, 0, 0));
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst search v", int'(bus.out_valid), 0);
        chk("rst search o", int'(bus.out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(3'd1, pk7(0, 0, 0, 0, 0, 0, 0), pk7(0, 0, 0, 0, 0, 0, 0));
        collect("after rst search", gold);

        // Reset mid-output: out must drop immediately.
        send(3'd1, pk7(11, 0, 0, 0, 0, 0, 0), pk7(3, 0, 0, 0, 0, 0, 0));
        got = 1'b0;
        for (int w = 0; w < 20000 && !got; w++) begin
            @(negedge clk);
            got = bus.out_valid;
        end
        chk("mid out reached", int'(got), 1);
        repeat (3) @(negedge clk);
        chk("mid out v before", int'(bus.out_valid), 1);
        chk("mid out b3", int'(bus.out), int'(gold[3]));
        #2 rst_n = 1'b0;
        #1 chk("rst out v", int'(bus.out_valid), 0);
        chk("rst out o", int'(bus.out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(3'd1, pk7(0, 0, 0, 0, 0, 0, 0), pk7(0, 0, 0, 0, 0, 0, 0));
        collect("after rst out", gold);

        // Back-to-back patterns with distinct answers.
        for (int i = 0; i < 16; i++) begin
            gen_rand(rn, rc, rr, re);
            send(rn, rc, rr);
            collect($sformatf("rand%0d", i), re);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
